// File: rtl/ha_array_accumulator_8x8.sv
// Sequential reducer: sums the four ha_array b/t row groups into an OUT_W-bit product, one group per cycle.
// Optional build macro HA_ACC_ZERO_SKIP_EN skips groups whose b and t rows are all zero.
module ha_array_accumulator_8x8 #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       ha_array_0_b,
    input  logic [6:0]       ha_array_1_b,
    input  logic [6:0]       ha_array_2_b,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [8:0]       ha_array_1_t,
    input  logic [8:0]       ha_array_2_t,
    input  logic [8:0]       ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [63:0]      hold_q, hold_d;
    logic [1:0]       idx_q, idx_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [63:0]      in_bus;
    logic [15:0]      cur_grp;
    logic             last_grp;

    // Each 16-bit slot of the holding register is {t[8:0], b[6:0]} for one group.
    assign in_bus = {ha_array_3_t, ha_array_3_b, ha_array_2_t, ha_array_2_b,
                     ha_array_1_t, ha_array_1_b, ha_array_0_t, ha_array_0_b};
    assign cur_grp = hold_q[{idx_q, 4'b0000} +: 16];

    // b rows carry two positions above t rows; the 11-bit group sum is then placed at 2^(2k).
    function automatic logic [OUT_W-1:0] group_val(input logic [15:0] grp, input logic [1:0] k);
        logic [10:0] s;
        s = {2'b00, grp[15:7]} + {2'b00, grp[6:0], 2'b00};
        return OUT_W'(s) << {k, 1'b0};
    endfunction

`ifdef HA_ACC_ZERO_SKIP_EN
    logic [3:0] mask_q, mask_d;
    logic [3:0] in_mask;
    logic [2:0] nxt;

    assign in_mask = {|{ha_array_3_b, ha_array_3_t}, |{ha_array_2_b, ha_array_2_t},
                      |{ha_array_1_b, ha_array_1_t}, |{ha_array_0_b, ha_array_0_t}};

    function automatic logic [1:0] first_set(input logic [3:0] mask);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Returns {found, index} of the lowest set mask bit strictly above cur.
    function automatic logic [2:0] next_set(input logic [3:0] mask, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign nxt      = next_set(mask_q, idx_q);
    assign last_grp = ~nxt[2];
`else
    assign last_grp = (idx_q == 2'd3);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ACC;
            ACC:     if (last_grp) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        product   = acc_q;
    end

    always_comb begin
        hold_d = hold_q;
        idx_d  = idx_q;
        acc_d  = acc_q;
`ifdef HA_ACC_ZERO_SKIP_EN
        mask_d = mask_q;
`endif
        if (state_q == IDLE && in_valid) begin
            hold_d = in_bus;
            acc_d  = '0;
`ifdef HA_ACC_ZERO_SKIP_EN
            mask_d = in_mask;
            idx_d  = first_set(in_mask);
`else
            idx_d  = 2'd0;
`endif
        end else if (state_q == ACC) begin
`ifdef HA_ACC_ZERO_SKIP_EN
            // An all-zero mask still burns one ACC cycle, but must not add anything.
            if (mask_q[idx_q]) acc_d = acc_q + group_val(cur_grp, idx_q);
            if (nxt[2]) idx_d = nxt[1:0];
`else
            acc_d = acc_q + group_val(cur_grp, idx_q);
            if (!last_grp) idx_d = idx_q + 2'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            idx_q  <= '0;
            acc_q  <= '0;
`ifdef HA_ACC_ZERO_SKIP_EN
            mask_q <= '0;
`endif
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
            acc_q  <= acc_d;
`ifdef HA_ACC_ZERO_SKIP_EN
            mask_q <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_ha_array_accumulator_8x8.sv
// Scoreboard bench for ha_array_accumulator_8x8; expected product and latency come from a bit-weight model.
module tb_ha_array_accumulator_8x8;

    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] product;
    logic [6:0]       b [4];
    logic [8:0]       t [4];

    typedef struct {
        logic [OUT_W-1:0] prod;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    ha_array_accumulator_8x8 #(.OUT_W(OUT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (b[0]),
        .ha_array_1_b (b[1]),
        .ha_array_2_b (b[2]),
        .ha_array_3_b (b[3]),
        .ha_array_0_t (t[0]),
        .ha_array_1_t (t[1]),
        .ha_array_2_t (t[2]),
        .ha_array_3_t (t[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            b[i] = '0;
            t[i] = '0;
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 4; i++) begin
            b[i] = 7'($urandom);
            t[i] = 9'($urandom);
        end
    endtask

    function automatic logic [OUT_W-1:0] model_product();
        longint s = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 9; j++) if (t[k][j]) s += longint'(1) << (2*k + j);
            for (int j = 0; j < 7; j++) if (b[k][j]) s += longint'(1) << (2*k + j + 2);
        end
        return OUT_W'(s);
    endfunction

    function automatic int model_latency();
`ifdef HA_ACC_ZERO_SKIP_EN
        int n = 0;
        for (int k = 0; k < 4; k++) if (b[k] != 0 || t[k] != 0) n++;
        return (n == 0) ? 1 : n;
`else
        return 4;
`endif
    endfunction

    task automatic run_set(input string tag, input int hold_cycles);
        exp_t e;
        int   w;
        int   lat;
        logic [OUT_W-1:0] first_prod;
        e.prod = model_product();
        e.lat  = model_latency();
        sb.push_back(e);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        scramble_inputs();
        lat = 0;
        while (!out_valid && lat < 40) begin
            check_val({tag, "_busy"}, 32'(in_ready), 32'd0);
            step();
            lat++;
        end
        e = sb.pop_front();
        check_val({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check_val({tag, "_product"}, 32'(product), 32'(e.prod));
        first_prod = product;
        for (int i = 0; i < hold_cycles; i++) begin
            step();
            check_val({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_val({tag, "_hold_prod"}, 32'(product), 32'(first_prod));
            check_val({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_post_ready"}, 32'(in_ready), 32'd1);
        check_val({tag, "_post_prod"}, 32'(product), 32'(first_prod));
        clear_inputs();
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_product", 32'(product), 32'd0);

        run_set("zero", 0);

        b[0][0] = 1'b1;
        run_set("b0_bit0", 0);

        t[3][8] = 1'b1;
        run_set("t3_bit8", 0);

        for (int k = 0; k < 4; k++) begin
            b[k] = '1;
            t[k] = '1;
        end
        run_set("all_ones", 0);

        for (int k = 0; k < 4; k++) begin
            b[k] = 7'h55 ^ 7'(k);
            t[k] = 9'h1A3 + 9'(k);
        end
        run_set("stall10", 10);

        for (int r = 0; r < 4; r++) begin
            scramble_inputs();
            if (r == 1) begin
                b[1] = '0;
                t[1] = '0;
            end
            run_set("random", r);
        end

        // Abort an operation with a one-cycle reset during its second ACC cycle.
        for (int k = 0; k < 4; k++) begin
            b[k] = '1;
            t[k] = '1;
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_val("abort_in_ready", 32'(in_ready), 32'd1);
        check_val("abort_out_valid", 32'(out_valid), 32'd0);
        check_val("abort_product", 32'(product), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1;
        end
        check_val("abort_no_output", 32'(seen), 32'd0);

        clear_inputs();
        t[1][0] = 1'b1;
        run_set("after_abort", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ha_array_accumulator_8x8.md
# ha_array_accumulator_8x8

Sequential final-stage reducer for the 8x8 approximate unsigned multipliers. It consumes the four half-adder array row groups produced by the partial-product compression stage, each group being a b/t vector pair. It then sums them into a 16-bit product over several cycles, behind valid/ready handshakes on both sides. It is the consumer at the far end of the ha_array interface and replaces a wide single-cycle adder tree where area matters more than latency.

## Interface

- OUT_W, 16, product width; sums wrap modulo 2^OUT_W.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  upstream holds a valid ha_array set.
- in_ready  output  1  block can accept a set; equals (state == IDLE).
- ha_array_0_b .. ha_array_3_b  input  7 each  carry rows of groups 0..3.
- ha_array_0_t .. ha_array_3_t  input  9 each  sum rows of groups 0..3.
- out_valid  output  1  product is valid; high only in DONE.
- out_ready  input  1  downstream accepts the product.
- product  output  OUT_W  accumulated result, registered.

## Operation

- Bit weights for group k (0..3):
  - t[j] has weight 2^(2k+j).
  - b[j] has weight 2^(2k+j+2).
- Group value: G_k = ({b,2'b00} + t) << 2k, computed at 11 bits and then zero-extended to OUT_W.
- product = (G_0 + G_1 + G_2 + G_3) mod 2^OUT_W. No saturation and no overflow flag.
- FSM states and transitions:
  - IDLE → ACC on in_valid && in_ready. At that edge, all 64 input bits are captured into a holding register, acc is cleared to 0, and the group index is set to the first group to visit.
  - In ACC, each cycle does acc <= acc + G_idx and advances idx. After the last visited group, the state moves to DONE.
  - In DONE, out_valid = 1 and product = acc. On out_ready the state returns to IDLE.
- product holds its value after DONE until the next acceptance clears acc. It changes during ACC.
- Inputs are sampled only at the acceptance edge. Later input changes have no effect.
- in_ready is low in ACC and DONE. There is no overlap of consecutive operations.
- Reset values:
  - state = IDLE
  - acc/product = 0
  - out_valid = 0
  - in_ready = 1 (from the first cycle after reset release)
  - holding register = 0
  - idx = 0
- Reset asserted mid-ACC or mid-DONE aborts the operation: no output and the partial sum is discarded. The handshake seen on the reset edge is ignored.

## Timing

- Acceptance edge E0.
- Without the macro:
  - ACC occupies edges E1..E4, adding groups 0,1,2,3 in order.
  - out_valid is high from just after E4. Fixed latency is 4 cycles.
- With the macro: latency = max(1, popcount(nonzero mask)) cycles.
- out_valid stays asserted while out_ready = 0. product is stable throughout.
- If out_ready = 1 in the first DONE cycle, DONE lasts exactly 1 cycle. in_ready rises on the following cycle.
- Throughput: one set per (latency + 2) cycles at best. That is 6 cycles without the macro.

## Configuration

- HA_ACC_ZERO_SKIP_EN defined:
  - At E0, a 4-bit mask is formed, with mask[k] = |{b_k, t_k}.
  - ACC visits only the set groups, in ascending k order.
  - An all-zero mask spends one idle ACC cycle (adding nothing), then enters DONE with product = 0.
- Not defined: all four groups are always visited, with fixed 4-cycle latency. The mask logic is absent.

## Test plan

- Reset, then all inputs zero with in_valid = 1:
  - Without the macro, out_valid 4 cycles after acceptance with product = 0.
  - With the macro, after 1 cycle with product = 0.
- Only ha_array_0_b[0] = 1 → product = 4.
- Only ha_array_3_t[8] = 1 → product = 16384. With the macro, latency is 1 cycle.
- All b and t bits = 1 → product = 1019·85 mod 65536 = 21079. With the macro, latency is 4 cycles.
- out_ready held low 10 cycles in DONE → out_valid and product stay stable and in_ready stays 0. Releasing out_ready returns in_ready = 1 on the next cycle. Input toggles during ACC do not alter the result.
- rst_n pulsed low for 1 cycle during the second ACC cycle → out_valid never rises for that set. After reset, state = IDLE, in_ready = 1 and product = 0. A new set {ha_array_1_t[0] = 1} then yields product = 4.
